rv_elastic_pipe: RTL and testbench

Parametrised elastic delay line: a DEPTH-stage, DATAW-bit pipeline with per-stage valid bits, a valid/ready handshake on both ends, bubble collapsing, synchronous flush and an occupancy counter. It replaces the plain enable-gated shift register wherever a delayed datapath must tolerate downstream backpressure without dropping or duplicating entries. Typical uses are response-latency matching in the LSU, and retiming between the issue and execute stages of the GPGPU core.

---
 rtl/rv_elastic_pipe_if.sv | 25 ++
 rtl/rv_elastic_pipe.sv | 67 ++++++
 tb/tb_rv_elastic_pipe.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_elastic_pipe_if.sv
// Valid/ready handshake bundle for rv_elastic_pipe: the upstream and downstream ends plus occupancy.
// The master side is the environment and the slave side is the pipe.
interface rv_elastic_pipe_if #(
    parameter int DATAW = 8,
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH + 1)
);
    logic             valid_in;
    logic [DATAW-1:0] data_in;
    logic             ready_in;
    logic             valid_out;
    logic [DATAW-1:0] data_out;
    logic             ready_out;
    logic [CNTW-1:0]  count;

    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, count
    );

    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, count
    );
endinterface

// File: rtl/rv_elastic_pipe.sv
// Elastic DEPTH-stage delay line with per-stage valid bits, bubble collapsing,
// synchronous flush and an occupancy counter.
module rv_elastic_pipe #(
    parameter int DATAW = 8,
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    rv_elastic_pipe_if.slave   bus
);
    logic [DEPTH-1:0] vld;
    logic [DATAW-1:0] dat [DEPTH];
    logic [DATAW-1:0] src [DEPTH];
    logic [DEPTH-1:0] mv;
    logic [DEPTH-1:0] inflow;
    logic [CNTW-1:0]  count_q;
    logic             adv;
    logic             fire_in;
    logic             fire_out;

    // Walk from the output end so each stage sees whether its successor frees up this cycle.
    always_comb begin
        mv  = '0;
        adv = bus.ready_out;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            mv[i] = vld[i] & adv;
            adv   = ~vld[i] | mv[i];
        end
    end

    assign bus.ready_in  = ~flush & (~vld[0] | mv[0]);
    assign fire_in       = bus.valid_in & bus.ready_in;
    assign fire_out      = vld[DEPTH-1] & bus.ready_out;
    assign bus.valid_out = vld[DEPTH-1];
    assign bus.data_out  = dat[DEPTH-1];
    assign bus.count     = count_q;

    always_comb begin
        inflow    = '0;
        inflow[0] = fire_in;
        src[0]    = bus.data_in;
        for (int i = 1; i < DEPTH; i++) begin
            inflow[i] = mv[i-1];
            src[i]    = dat[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld     <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else if (flush) begin
            vld     <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                vld[i] <= inflow[i] | (vld[i] & ~mv[i]);
                // Payload only loads on inflow so idle bits never toggle.
                if (inflow[i]) dat[i] <= src[i];
            end
            count_q <= count_q + CNTW'(fire_in) - CNTW'(fire_out);
        end
    end
endmodule

// File: tb/tb_rv_elastic_pipe.sv
// Directed self-checking bench for rv_elastic_pipe at DATAW=8, DEPTH=3.
module tb_rv_elastic_pipe;
    localparam int DATAW = 8;
    localparam int DEPTH = 3;
    localparam int CNTW  = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    rv_elastic_pipe_if #(.DATAW(DATAW), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

    rv_elastic_pipe #(.DATAW(DATAW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_cnt++;
        if (bus.valid_out !== 1'b0) $display("FAIL reset_valid_out got %b want 0", bus.valid_out);
        else pass_cnt++;
        chk_cnt++;
        if (bus.data_out !== 8'h00) $display("FAIL reset_data_out got %h want 00", bus.data_out);
        else pass_cnt++;
        chk_cnt++;
        if (bus.count !== 2'd0) $display("FAIL reset_count got %0d want 0", bus.count);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ready_in !== 1'b1) $display("FAIL reset_ready_in got %b want 1", bus.ready_in);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [7:0] din [4];
        logic       exp_vo [7];
        logic [7:0] exp_d [7];
        logic [1:0] exp_c [7];
        din = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_vo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_d  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        exp_c  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        bus.ready_out = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.valid_in = (k < 4);
            bus.data_in  = (k < 4) ? din[k] : 8'h00;
            #1;
            if (k < 4) begin
                chk_cnt++;
                if (bus.ready_in !== 1'b1) $display("FAIL stream_ready_in k=%0d got %b want 1", k, bus.ready_in);
                else pass_cnt++;
            end
            tick();
            chk_cnt++;
            if (bus.valid_out !== exp_vo[k]) $display("FAIL stream_valid_out k=%0d got %b want %b", k, bus.valid_out, exp_vo[k]);
            else pass_cnt++;
            if (exp_vo[k]) begin
                chk_cnt++;
                if (bus.data_out !== exp_d[k]) $display("FAIL stream_data_out k=%0d got %h want %h", k, bus.data_out, exp_d[k]);
                else pass_cnt++;
            end
            chk_cnt++;
            if (bus.count !== exp_c[k]) $display("FAIL stream_count k=%0d got %0d want %0d", k, bus.count, exp_c[k]);
            else pass_cnt++;
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic test_backpressure();
        logic       exp_rdy [4];
        logic [1:0] exp_c [4];
        logic [7:0] exp_d [3];
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_c   = '{2'd1, 2'd2, 2'd3, 2'd3};
        exp_d   = '{8'hA2, 8'hA3, 8'hA4};
        bus.ready_out = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 8'hA1 + 8'(k);
            #1;
            chk_cnt++;
            if (bus.ready_in !== exp_rdy[k]) $display("FAIL bp_ready_in k=%0d got %b want %b", k, bus.ready_in, exp_rdy[k]);
            else pass_cnt++;
            tick();
            chk_cnt++;
            if (bus.count !== exp_c[k]) $display("FAIL bp_count k=%0d got %0d want %0d", k, bus.count, exp_c[k]);
            else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hA1)
            $display("FAIL bp_hold got vo=%b d=%h want vo=1 d=a1", bus.valid_out, bus.data_out);
        else pass_cnt++;
        bus.ready_out = 1'b1;
        #1;
        chk_cnt++;
        if (bus.ready_in !== 1'b1) $display("FAIL bp_release_ready_in got %b want 1", bus.ready_in);
        else pass_cnt++;
        tick();
        bus.valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== exp_d[k])
                $display("FAIL bp_drain k=%0d got vo=%b d=%h want vo=1 d=%h", k, bus.valid_out, bus.data_out, exp_d[k]);
            else pass_cnt++;
            tick();
        end
        chk_cnt++;
        if (bus.valid_out !== 1'b0 || bus.count !== 2'd0)
            $display("FAIL bp_empty got vo=%b cnt=%0d want vo=0 cnt=0", bus.valid_out, bus.count);
        else pass_cnt++;
    endtask

    task automatic test_bubble();
        bus.ready_out = 1'b0;
        bus.valid_in  = 1'b1;
        bus.data_in   = 8'h01;
        tick();
        bus.valid_in = 1'b0;
        tick();
        tick();
        chk_cnt++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h01)
            $display("FAIL bubble_collapse got vo=%b d=%h want vo=1 d=01", bus.valid_out, bus.data_out);
        else pass_cnt++;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h02;
        tick();
        bus.valid_in = 1'b0;
        tick();
        chk_cnt++;
        if (bus.count !== 2'd2) $display("FAIL bubble_count got %0d want 2", bus.count);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ready_in !== 1'b1) $display("FAIL bubble_ready_in got %b want 1", bus.ready_in);
        else pass_cnt++;
        bus.ready_out = 1'b1;
        tick();
        chk_cnt++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h02)
            $display("FAIL bubble_packed got vo=%b d=%h want vo=1 d=02", bus.valid_out, bus.data_out);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.valid_out !== 1'b0 || bus.count !== 2'd0)
            $display("FAIL bubble_empty got vo=%b cnt=%0d want vo=0 cnt=0", bus.valid_out, bus.count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bus.ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 8'h50 + 8'(k);
            tick();
        end
        bus.ready_out = 1'b1;
        for (int j = 0; j < 10; j++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 8'h53 + 8'(j);
            #1;
            chk_cnt++;
            if (bus.ready_in !== 1'b1) $display("FAIL b2b_ready_in j=%0d got %b want 1", j, bus.ready_in);
            else pass_cnt++;
            tick();
            chk_cnt++;
            if (bus.count !== 2'd3 || bus.data_out !== 8'h51 + 8'(j) || bus.valid_out !== 1'b1)
                $display("FAIL b2b_flow j=%0d got vo=%b d=%h cnt=%0d want vo=1 d=%h cnt=3",
                         j, bus.valid_out, bus.data_out, bus.count, 8'h51 + 8'(j));
            else pass_cnt++;
        end
        bus.valid_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_cnt++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h5B + 8'(k))
                $display("FAIL b2b_drain k=%0d got vo=%b d=%h want vo=1 d=%h", k, bus.valid_out, bus.data_out, 8'h5B + 8'(k));
            else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if (bus.valid_out !== 1'b0 || bus.count !== 2'd0)
            $display("FAIL b2b_empty got vo=%b cnt=%0d want vo=0 cnt=0", bus.valid_out, bus.count);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        bus.ready_out = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 8'hC1 + 8'(k);
            tick();
        end
        chk_cnt++;
        if (bus.count !== 2'd2) $display("FAIL flush_precount got %0d want 2", bus.count);
        else pass_cnt++;
        flush        = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hC3;
        #1;
        chk_cnt++;
        if (bus.ready_in !== 1'b0) $display("FAIL flush_ready_in got %b want 0", bus.ready_in);
        else pass_cnt++;
        tick();
        flush        = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        chk_cnt++;
        if (bus.valid_out !== 1'b0 || bus.count !== 2'd0 || bus.ready_in !== 1'b1)
            $display("FAIL flush_after got vo=%b cnt=%0d rdy=%b want vo=0 cnt=0 rdy=1", bus.valid_out, bus.count, bus.ready_in);
        else pass_cnt++;
        tick();
        tick();
        tick();
        chk_cnt++;
        if (bus.valid_out !== 1'b0 || bus.count !== 2'd0)
            $display("FAIL flush_no_capture got vo=%b cnt=%0d want vo=0 cnt=0", bus.valid_out, bus.count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus.ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 8'hD1 + 8'(k);
            tick();
        end
        #1;
        chk_cnt++;
        if (bus.count !== 2'd3 || bus.ready_in !== 1'b0 || bus.data_out !== 8'hD1)
            $display("FAIL rstmid_full got cnt=%0d rdy=%b d=%h want cnt=3 rdy=0 d=d1", bus.count, bus.ready_in, bus.data_out);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        chk_cnt++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00)
            $display("FAIL rstmid_out got vo=%b d=%h want vo=0 d=00", bus.valid_out, bus.data_out);
        else pass_cnt++;
        chk_cnt++;
        if (bus.count !== 2'd0 || bus.ready_in !== 1'b1)
            $display("FAIL rstmid_state got cnt=%0d rdy=%b want cnt=0 rdy=1", bus.count, bus.ready_in);
        else pass_cnt++;
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.data_in   = 8'h00;
        bus.ready_out = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
